// File: rtl/keypad_pkg.sv
// keypad_pkg: FSM state type, key code constants and snapshot-bit-to-key-code mapping
package keypad_pkg;
  typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} state_t;
  localparam logic [3:0] KEY_A = 4'd10;
  localparam logic [3:0] KEY_B = 4'd11;
  localparam logic [3:0] KEY_C = 4'd12;
  localparam logic [3:0] KEY_D = 4'd13;
  localparam logic [3:0] KEY_STAR = 4'd14;
  localparam logic [3:0] KEY_HASH = 4'd15;
  function automatic logic [3:0] key_of(input logic [3:0] idx);
    logic [3:0] r, c;
    r = {2'b00, idx[3:2]};
    c = {2'b00, idx[1:0]};
    return c == 4'd3 ? KEY_A + r : r != 4'd3 ? r * 4'd3 + c + 4'd1 : c == 4'd0 ? KEY_STAR : c == 4'd1 ? 4'd0 : KEY_HASH;
  endfunction
endpackage

// File: rtl/keypad_scan.sv
// keypad_scan: row synchroniser, column scan and 16-bit snapshot; ports clk, reset, row in; col, snap, scan_end out
module keypad_scan #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [15:0] snap,
  output logic        scan_end
);
  localparam int W = $clog2(SCAN_DIV);
  logic [W-1:0] dwell;
  logic [1:0] idx;
  logic [3:0] row_m, row_s;
  logic [15:0] acc;
  logic last;
  assign last = dwell == W'(SCAN_DIV - 1);
  assign col = ~(4'b0001 << idx);
  assign scan_end = last && idx == 2'd3;
  always_comb begin
    snap = acc;
    for (int i = 0; i < 16; i++)
      if (last && idx == 2'(i % 4)) snap[i] = ~row_s[i / 4];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      row_m <= '0;
      row_s <= '0;
      dwell <= '0;
      idx   <= '0;
      acc   <= '0;
    end else begin
      row_m <= row;
      row_s <= row_m;
      dwell <= last ? '0 : dwell + W'(1);
      idx   <= idx + {1'b0, last};
      acc   <= snap;
    end
  end
endmodule

// File: rtl/keypad_entry.sv
// keypad_entry: debounced 4x4 keypad events and two-digit entry; ports clk, reset, row in; col, key_valid, key_code, entry, entry_done out
module keypad_entry import keypad_pkg::*; #(
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic [6:0] entry,
  output logic       entry_done
);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n, nc;
  logic [3:0] cand, cand_n, code_n, k, k_idx;
  logic [6:0] entry_n, digit;
  logic [15:0] snap;
  logic scan_end, single, none, accept, kv_n, done_n;
  keypad_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .clk(clk), .reset(reset), .row(row), .col(col), .snap(snap), .scan_end(scan_end)
  );
  assign none = snap == '0;
  assign single = !none && (snap & (snap - 16'd1)) == '0;
  always_comb begin
    k_idx = '0;
    for (int i = 0; i < 16; i++)
      if (snap[i]) k_idx = 4'(i);
  end
  assign k = key_of(k_idx);
  assign digit = 7'((entry % 7'd10) * 7'd10) + 7'(k);
  // nc is the match count this scan would produce: continue counting on a repeat, restart at 1 otherwise
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cand_n  = cand;
    code_n  = key_code;
    entry_n = entry;
    kv_n    = 1'b0;
    done_n  = 1'b0;
    nc      = ((state == PRESS_CHK && k == cand) || state == REL_CHK) ? cnt + CW'(1) : CW'(1);
    accept  = nc == CW'(DEBOUNCE_SCANS);
    if (scan_end) begin
      if (state == IDLE || state == PRESS_CHK) begin
        if (single) begin
          cand_n  = k;
          cnt_n   = nc;
          state_n = accept ? HELD : PRESS_CHK;
          kv_n    = accept;
          done_n  = accept && k == KEY_HASH;
          code_n  = accept ? k : key_code;
          entry_n = !accept ? entry : k <= 4'd9 ? digit : k == KEY_STAR ? 7'd0 : entry;
        end else state_n = IDLE;
      end else if (none) begin
        cnt_n   = nc;
        state_n = accept ? IDLE : REL_CHK;
      end else state_n = HELD;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      cand       <= '0;
      key_valid  <= 1'b0;
      key_code   <= '0;
      entry      <= '0;
      entry_done <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      cand       <= cand_n;
      key_valid  <= kv_n;
      key_code   <= code_n;
      entry      <= entry_n;
      entry_done <= done_n;
    end
  end
endmodule
